seq_recorder: RTL and testbench
===============================

SEQ_RECORDER -- requirements
Module: seq_recorder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of button/LED channels (bits per sequence step).
REQ-002 SHALL have parameter DEPTH, default 16: maximum number of stored steps, at least 2.
REQ-003 SHALL have parameter AW = $clog2(DEPTH+1), derived: width of the length and index fields.
REQ-004 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port START, input, 1: begin an operation selected by MODE; sampled only in IDLE.
REQ-007 SHALL have port MODE, input, 2: operation select, 00 record, 01 playback, 10 compare, 11 reserved.
REQ-008 SHALL have port LEN, input, AW: record length, latched at START in record mode.
REQ-009 SHALL have port STEP, input, 1: one-cycle strobe that advances one sequence step.
REQ-010 SHALL have port BTN, input, WIDTH: button pattern, sampled on STEP in record and compare modes.
REQ-011 SHALL have port SEQ, output, WIDTH: pattern of the current playback step; 0 outside playback.
REQ-012 SHALL have port IDX, output, AW: current step index.
REQ-013 SHALL have port COUNT, output, AW: number of valid stored steps.
REQ-014 SHALL have port BUSY, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port DONE, output, 1: one-cycle pulse when an operation ends.
REQ-016 SHALL have port MATCH, output, 1: the last compare finished with every step equal.
REQ-017 SHALL have port ERR, output, 1: the last compare stopped on a mismatched step.

Function
REQ-018 SHALL implement the states IDLE, REC, PLAY and CMP.
REQ-019 SHALL, in IDLE with START=1, go to REC/PLAY/CMP for MODE 00/01/10 on the next edge, set IDX=0, and stay in IDLE for MODE 11.
REQ-020 SHALL ignore START while BUSY=1.
REQ-021 SHALL ignore a STEP that occurs in the same cycle as an accepted START, or in IDLE.
REQ-022 SHALL, on START into REC, latch the effective length L = LEN, replaced by DEPTH when LEN=0 or LEN>DEPTH.
REQ-023 SHALL, in REC on each STEP, write BTN to mem[IDX] and increment IDX.
REQ-024 SHALL, in REC on the L-th STEP, set COUNT=L, return to IDLE, and pulse DONE in the next cycle.
REQ-025 SHALL drive SEQ, in PLAY, with mem[IDX], updated in the same cycle IDX changes, with no extra latency.
REQ-026 SHALL, in PLAY on each STEP, increment IDX.
REQ-027 SHALL, in PLAY on the COUNT-th STEP, return to IDLE with SEQ=0 and pulse DONE.
REQ-028 SHALL, in PLAY with COUNT=0, return to IDLE one cycle after entry and pulse DONE without needing a STEP.
REQ-029 SHALL, on START into CMP, clear MATCH and ERR.
REQ-030 SHALL, in CMP on each STEP, compare BTN with mem[IDX]: equal increments IDX; unequal sets ERR=1, returns to IDLE and pulses DONE.
REQ-031 SHALL, in CMP after COUNT equal steps, set MATCH=1, return to IDLE and pulse DONE.
REQ-032 SHALL, in CMP with COUNT=0, set MATCH=1 and finish as in REQ-028.
REQ-033 SHALL hold MATCH and ERR until the next CMP start or reset; MATCH and ERR are never high together.
REQ-034 SHALL keep COUNT through PLAY and CMP, and change it only when a REC completes.
REQ-035 SHALL, on a REC aborted by reset, leave COUNT=0.
REQ-036 SHALL deassert BUSY in the same cycle DONE is high.
REQ-037 SHALL keep IDX within 0..DEPTH-1 while active, so no wrap-around is possible.

Reset
REQ-038 SHALL, with RST=1, on the next edge set IDLE, IDX=0, COUNT=0, SEQ=0, BUSY=0, DONE=0, MATCH=0, ERR=0.
REQ-039 SHALL give RST priority over START and STEP in the same cycle, including in the middle of an operation.
REQ-040 SHALL NOT clear the memory contents on reset; they are undefined until written.

Verification
REQ-041 SHALL cover: record with LEN=3 and BTN 01,02,04 on three STEPs, then playback -> SEQ=01,02,04 across steps, then 0; COUNT=3; one DONE per operation.
REQ-042 SHALL cover: compare 01,02,04 against the stored 01,02,04 -> MATCH=1 and ERR=0 after the 3rd STEP; compare 01,08 -> ERR=1 and DONE after the 2nd STEP, with IDX frozen at 1.
REQ-043 SHALL cover: record with LEN=0 and with LEN=DEPTH+5 -> exactly DEPTH STEPs are accepted, then COUNT=DEPTH.
REQ-044 SHALL cover: RST asserted after 2 of 4 REC steps -> the next cycle is IDLE with COUNT=0, and a following playback gives DONE one cycle after entry.
REQ-045 SHALL cover: START and STEP in the same cycle, START while BUSY, and MODE=11 -> the STEP is ignored and the state is unchanged.

Source files
------------

// File: rtl/seq_recorder.sv
// Button-sequence recorder: records up to DEPTH patterns, plays them back on
// demand, or compares a newly entered sequence against the stored one.
module seq_recorder #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [1:0]       MODE,
   input  logic [AW-1:0]    LEN,
   input  logic             STEP,
   input  logic [WIDTH-1:0] BTN,
   output logic [WIDTH-1:0] SEQ,
   output logic [AW-1:0]    IDX,
   output logic [AW-1:0]    COUNT,
   output logic             BUSY,
   output logic             DONE,
   output logic             MATCH,
   output logic             ERR
);

   localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, REC, PLAY, CMP} state_t;

   state_t            state;
   logic [AW-1:0]     idx;
   logic [AW-1:0]     idx_next;
   logic [AW-1:0]     count;
   logic [AW-1:0]     rec_len;
   logic [AW-1:0]     eff_len;
   logic              done;
   logic              match;
   logic              err;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [MAW-1:0]    addr;
   logic [WIDTH-1:0]  cur;

   // idx never exceeds DEPTH-1 while a step is pending, so truncation is safe
   assign addr     = idx[MAW-1:0];
   assign cur      = mem[addr];
   assign idx_next = idx + AW'(1);
   assign eff_len  = (LEN == '0 || LEN > AW'(DEPTH)) ? AW'(DEPTH) : LEN;

   // Storage is deliberately not reset so it can map onto plain RAM.
   always_ff @(posedge CLK) begin
      if (!RST && state == REC && STEP) begin
         mem[addr] <= BTN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         idx     <= '0;
         count   <= '0;
         rec_len <= '0;
         done    <= 1'b0;
         match   <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  case (MODE)
                     2'b00: begin
                        state   <= REC;
                        idx     <= '0;
                        rec_len <= eff_len;
                     end
                     2'b01: begin
                        state <= PLAY;
                        idx   <= '0;
                     end
                     2'b10: begin
                        state <= CMP;
                        idx   <= '0;
                        match <= 1'b0;
                        err   <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            REC: begin
               if (STEP) begin
                  idx <= idx_next;
                  if (idx_next == rec_len) begin
                     count <= rec_len;
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            // An empty memory finishes on its own one cycle after entry.
            PLAY: begin
               if (count == '0) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end else if (STEP) begin
                  idx <= idx_next;
                  if (idx_next == count) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            CMP: begin
               if (count == '0) begin
                  match <= 1'b1;
                  state <= IDLE;
                  done  <= 1'b1;
               end else if (STEP) begin
                  if (BTN != cur) begin
                     err   <= 1'b1;
                     state <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     idx <= idx_next;
                     if (idx_next == count) begin
                        match <= 1'b1;
                        state <= IDLE;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign SEQ   = (state == PLAY) ? cur : '0;
   assign IDX   = idx;
   assign COUNT = count;
   assign BUSY  = (state != IDLE);
   assign DONE  = done;
   assign MATCH = match;
   assign ERR   = err;

endmodule

// File: tb/tb_seq_recorder.sv
// Directed bench for seq_recorder with hand-computed expectations per scenario.
module tb_seq_recorder;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       mode;
   logic [AW-1:0]    len;
   logic             step;
   logic [WIDTH-1:0] btn;
   logic [WIDTH-1:0] seq;
   logic [AW-1:0]    idx;
   logic [AW-1:0]    count;
   logic             busy;
   logic             done;
   logic             match;
   logic             err;

   int total = 0;
   int bad   = 0;

   seq_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK(clk), .RST(rst), .START(start), .MODE(mode), .LEN(len),
      .STEP(step), .BTN(btn), .SEQ(seq), .IDX(idx), .COUNT(count),
      .BUSY(busy), .DONE(done), .MATCH(match), .ERR(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [1:0] m, input logic [AW-1:0] l);
      start = 1'b1; mode = m; len = l;
      tick();
      start = 1'b0;
   endtask

   task automatic do_step(input logic [WIDTH-1:0] b);
      step = 1'b1; btn = b;
      tick();
      step = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; mode = 2'b00; len = 3; step = 1'b1; btn = 8'hFF;
      tick();
      rst = 1'b0; start = 1'b0; step = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0h exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%0h exp=0", done); end
      total++; if (count !== 0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
      total++; if (idx !== 0) begin bad++; $display("[TB] FAIL reset_idx got=%0d exp=0", idx); end
      total++; if (seq !== 0) begin bad++; $display("[TB] FAIL reset_seq got=%0h exp=0", seq); end
      total++; if (match !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags got=%0b%0b exp=00", match, err); end
   endtask

   task automatic test_record();
      do_start(2'b00, 3);
      total++; if (busy !== 1'b1 || idx !== 0) begin bad++; $display("[TB] FAIL rec_entry got busy=%0b idx=%0d exp busy=1 idx=0", busy, idx); end
      do_step(8'h01);
      total++; if (idx !== 1) begin bad++; $display("[TB] FAIL rec_idx1 got=%0d exp=1", idx); end
      do_step(8'h02);
      total++; if (idx !== 2 || done !== 1'b0) begin bad++; $display("[TB] FAIL rec_idx2 got idx=%0d done=%0b exp idx=2 done=0", idx, done); end
      do_step(8'h04);
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rec_done got done=%0b busy=%0b exp done=1 busy=0", done, busy); end
      total++; if (count !== 3) begin bad++; $display("[TB] FAIL rec_count got=%0d exp=3", count); end
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rec_done_pulse got=%0b exp=0", done); end
   endtask

   task automatic test_playback();
      total++; if (seq !== 8'h00) begin bad++; $display("[TB] FAIL play_idle_seq got=%0h exp=0", seq); end
      do_start(2'b01, 0);
      total++; if (seq !== 8'h01 || busy !== 1'b1) begin bad++; $display("[TB] FAIL play_s0 got seq=%0h busy=%0b exp seq=01 busy=1", seq, busy); end
      do_step(8'h00);
      total++; if (seq !== 8'h02) begin bad++; $display("[TB] FAIL play_s1 got=%0h exp=02", seq); end
      do_step(8'h00);
      total++; if (seq !== 8'h04 || done !== 1'b0) begin bad++; $display("[TB] FAIL play_s2 got seq=%0h done=%0b exp seq=04 done=0", seq, done); end
      do_step(8'h00);
      total++; if (seq !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL play_end got seq=%0h done=%0b busy=%0b exp 0/1/0", seq, done, busy); end
      total++; if (count !== 3) begin bad++; $display("[TB] FAIL play_count got=%0d exp=3", count); end
      tick();
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL play_done_pulse got=%0b exp=0", done); end
   endtask

   task automatic test_compare_match();
      do_start(2'b10, 0);
      total++; if (match !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL cmp_entry got m=%0b e=%0b b=%0b exp 0/0/1", match, err, busy); end
      do_step(8'h01);
      do_step(8'h02);
      total++; if (match !== 1'b0 || done !== 1'b0 || idx !== 2) begin bad++; $display("[TB] FAIL cmp_mid got m=%0b d=%0b idx=%0d exp 0/0/2", match, done, idx); end
      do_step(8'h04);
      total++; if (match !== 1'b1 || err !== 1'b0 || done !== 1'b1) begin bad++; $display("[TB] FAIL cmp_match got m=%0b e=%0b d=%0b exp 1/0/1", match, err, done); end
      tick();
      total++; if (match !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL cmp_match_hold got m=%0b d=%0b exp 1/0", match, done); end
   endtask

   task automatic test_compare_err();
      do_start(2'b10, 0);
      total++; if (match !== 1'b0) begin bad++; $display("[TB] FAIL err_clear_match got=%0b exp=0", match); end
      do_step(8'h01);
      total++; if (idx !== 1 || err !== 1'b0) begin bad++; $display("[TB] FAIL err_step1 got idx=%0d e=%0b exp 1/0", idx, err); end
      do_step(8'h08);
      total++; if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || match !== 1'b0) begin bad++; $display("[TB] FAIL err_stop got e=%0b d=%0b b=%0b m=%0b exp 1/1/0/0", err, done, busy, match); end
      total++; if (idx !== 1) begin bad++; $display("[TB] FAIL err_idx got=%0d exp=1", idx); end
      tick();
      total++; if (err !== 1'b1 || count !== 3) begin bad++; $display("[TB] FAIL err_hold got e=%0b count=%0d exp 1/3", err, count); end
   endtask

   task automatic test_len_bounds();
      logic [AW-1:0] lens [2];
      lens[0] = 0;
      lens[1] = AW'(DEPTH + 5);
      for (int k = 0; k < 2; k++) begin
         do_start(2'b00, lens[k]);
         for (int i = 0; i < DEPTH - 1; i++) do_step(WIDTH'(8'h20 * k + i));
         total++; if (busy !== 1'b1 || done !== 1'b0 || idx !== AW'(DEPTH - 1)) begin bad++; $display("[TB] FAIL len%0d_pre got b=%0b d=%0b idx=%0d exp 1/0/%0d", k, busy, done, idx, DEPTH - 1); end
         do_step(WIDTH'(8'h20 * k + DEPTH - 1));
         total++; if (done !== 1'b1 || count !== AW'(DEPTH)) begin bad++; $display("[TB] FAIL len%0d_done got d=%0b count=%0d exp 1/%0d", k, done, count, DEPTH); end
         do_step(8'hEE);
         total++; if (busy !== 1'b0 || count !== AW'(DEPTH)) begin bad++; $display("[TB] FAIL len%0d_extra got b=%0b count=%0d exp 0/%0d", k, busy, count, DEPTH); end
      end
      do_start(2'b01, 0);
      for (int i = 0; i < DEPTH; i++) begin
         total++; if (seq !== WIDTH'(8'h20 + i)) begin bad++; $display("[TB] FAIL full_play%0d got=%0h exp=%0h", i, seq, 8'h20 + i); end
         do_step(8'h00);
      end
      total++; if (done !== 1'b1 || seq !== 0) begin bad++; $display("[TB] FAIL full_play_end got d=%0b seq=%0h exp 1/0", done, seq); end
   endtask

   task automatic test_reset_abort();
      do_start(2'b00, 4);
      do_step(8'hAA);
      do_step(8'hBB);
      rst = 1'b1; step = 1'b1; btn = 8'hCC; start = 1'b1; mode = 2'b01;
      tick();
      rst = 1'b0; step = 1'b0; start = 1'b0;
      total++; if (busy !== 1'b0 || count !== 0 || idx !== 0 || done !== 1'b0) begin bad++; $display("[TB] FAIL abort got b=%0b count=%0d idx=%0d d=%0b exp 0/0/0/0", busy, count, idx, done); end
      do_start(2'b01, 0);
      total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL empty_play_entry got b=%0b d=%0b exp 1/0", busy, done); end
      tick();
      total++; if (done !== 1'b1 || busy !== 1'b0 || seq !== 0) begin bad++; $display("[TB] FAIL empty_play_done got d=%0b b=%0b seq=%0h exp 1/0/0", done, busy, seq); end
      do_start(2'b10, 0);
      tick();
      total++; if (match !== 1'b1 || err !== 1'b0 || done !== 1'b1) begin bad++; $display("[TB] FAIL empty_cmp got m=%0b e=%0b d=%0b exp 1/0/1", match, err, done); end
   endtask

   task automatic test_back_to_back();
      start = 1'b1; mode = 2'b00; len = 2; step = 1'b1; btn = 8'h99;
      tick();
      start = 1'b0; step = 1'b0;
      total++; if (busy !== 1'b1 || idx !== 0) begin bad++; $display("[TB] FAIL same_cycle got b=%0b idx=%0d exp 1/0", busy, idx); end
      start = 1'b1; mode = 2'b01;
      do_step(8'h11);
      total++; if (busy !== 1'b1 || idx !== 1) begin bad++; $display("[TB] FAIL start_busy got b=%0b idx=%0d exp 1/1", busy, idx); end
      start = 1'b0;
      do_step(8'h22);
      total++; if (done !== 1'b1 || count !== 2) begin bad++; $display("[TB] FAIL b2b_rec got d=%0b count=%0d exp 1/2", done, count); end
      do_start(2'b01, 0);
      total++; if (seq !== 8'h11) begin bad++; $display("[TB] FAIL b2b_play0 got=%0h exp=11", seq); end
      start = 1'b1; mode = 2'b00; len = 5;
      do_step(8'h00);
      start = 1'b0;
      total++; if (seq !== 8'h22 || count !== 2) begin bad++; $display("[TB] FAIL b2b_play1 got seq=%0h count=%0d exp 22/2", seq, count); end
      do_step(8'h00);
      total++; if (done !== 1'b1 || idx !== 2) begin bad++; $display("[TB] FAIL b2b_play_end got d=%0b idx=%0d exp 1/2", done, idx); end
      start = 1'b1; mode = 2'b11; step = 1'b1; btn = 8'h55;
      tick();
      start = 1'b0; step = 1'b0;
      total++; if (busy !== 1'b0 || idx !== 2 || count !== 2 || done !== 1'b0) begin bad++; $display("[TB] FAIL mode11 got b=%0b idx=%0d count=%0d d=%0b exp 0/2/2/0", busy, idx, count, done); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mode11_stay got=%0b exp=0", busy); end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; mode = 2'b00; len = '0; step = 1'b0; btn = '0;
      test_reset();
      test_record();
      test_playback();
      test_compare_match();
      test_compare_err();
      test_len_bounds();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
